uart_tx_parity: RTL

UART_TX_PARITY -- requirements
Module: uart_tx_parity

---
 rtl/uart_tx_parity_pkg.sv | 28 ++
 rtl/uart_tx_parity.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_parity_pkg.sv
// Shared UART definitions: frame FSM encodings and oversampling constants,
// imported by both the transmitter and the receiver so the two ends agree.
package uart_tx_parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // s_tick periods per start, data and parity bit
    localparam int unsigned OVERSAMPLE = 16;

    // Count-of-ones parity of the low nbits of d, seeded with odd_sel
    function automatic logic frame_parity(input logic [7:0] d,
                                          input int unsigned nbits,
                                          input logic odd_sel);
        logic acc;
        acc = odd_sel;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) acc = acc ^ d[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// UART transmitter with optional even/odd parity, clocked by an external
// 16x oversampling tick; the line output is registered and glitch-free.
module uart_tx_parity
    import uart_tx_parity_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_STOP = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);
    localparam logic       P_SEED    = (PARITY_ODD != 0);

    uart_state_e r_state;
    logic [4:0]  r_s;
    logic [2:0]  r_n;
    logic [7:0]  r_b;
    logic        r_p;
    logic        r_tx;

    uart_state_e w_state_next;
    logic [4:0]  w_s_next;
    logic [2:0]  w_n_next;
    logic [7:0]  w_b_next;
    logic        w_p_next;
    logic        w_tx_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_p     <= w_p_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_p_next     = r_p;
        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_state_next = ST_START;
                    w_b_next     = din;
                    w_s_next     = '0;
                    w_p_next     = P_SEED;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_state_next = ST_DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_p_next = r_p ^ r_b[0];
                        w_b_next = r_b >> 1;
                        w_s_next = '0;
                        if (r_n == LAST_BIT) begin
                            w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            w_n_next = r_n + 3'd1;
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_state_next = ST_STOP;
                        w_s_next     = '0;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == LAST_STOP) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_s_next     = '0;
                w_n_next     = '0;
            end
        endcase

        // Line value follows the next state so tx switches on the same edge
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_b_next[0];
            ST_PARITY: w_tx_next = w_p_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        tx           = r_tx;
        tx_busy      = (r_state != ST_IDLE);
        tx_done_tick = (r_state == ST_STOP) && s_tick && (r_s == LAST_STOP) && !reset;
    end

endmodule
